// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared encodings for the I2S / left-justified / TDM serial transmitter:
//   i2s_mode_e  : serial framing mode as seen on the mode input
//   i2s_state_e : frame sequencer state
//   mode_decode : maps the raw 2-bit mode input to a framing mode
//                 (the reserved code falls back to I2S)
// ---------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [1:0] {
        MODE_I2S  = 2'd0,
        MODE_LJ   = 2'd1,
        MODE_TDM  = 2'd2,
        MODE_RSVD = 2'd3
    } i2s_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    function automatic i2s_mode_e mode_decode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_LJ;
            2'd2:    return MODE_TDM;
            default: return MODE_I2S;
        endcase
    endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx_if
// Frame push bus into the transmitter.
//   s_data  : one frame, channel 0 in the LSBs (FRAME_DW = CHANNELS*SAMPLE_DW)
//   s_valid : source has a frame on s_data
//   s_ready : transmitter can accept a frame this cycle
// Modports: master = frame source, slave = transmitter.
// ---------------------------------------------------------------------------
interface i2s_tdm_tx_if #(
    parameter int FRAME_DW = 48
);
    logic [FRAME_DW-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/i2s_frame_fifo.sv
// ---------------------------------------------------------------------------
// i2s_frame_fifo
// Synchronous frame FIFO with first-word-fall-through read: rd_data_o always
// shows the head entry, and rd_en_i retires it on the clock edge.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en_i/wr_data_i : write request and data (ignored when full)
//   rd_en_i        : pop request (ignored when empty)
//   rd_data_o      : head entry
//   full_o/empty_o : status flags
//   level_o        : number of entries held
// ---------------------------------------------------------------------------
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             wr_fire, rd_fire;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_fire && !rd_fire)      level_d = level_q + LW'(1);
        else if (rd_fire && !wr_fire) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx
// Serial audio transmitter for I2S, left-justified and TDM/DSP framing.
// Frames are pushed into a small FIFO and serialized MSB first, one slot of
// SLOT_DW bit clocks per channel, each sample left-aligned in its slot.
// Ports:
//   sclk       : bit clock (rising edge)
//   rst_n      : asynchronous active-low reset
//   enable     : start/stop transmission; a running frame always completes
//   mode       : 0=I2S, 1=LJ, 2=TDM, 3=I2S; sampled only when a frame loads
//   s_bus      : frame push handshake (s_data/s_valid/s_ready)
//   lrclk      : word select (I2S/LJ) or one-cycle frame sync (TDM)
//   sdata      : serial data
//   underrun   : one-cycle pulse when a frame load found the FIFO empty
//   fifo_level : frames buffered
// Output timing: the edge that loads a frame also registers bit position 0,
// so the first frame bit is on sdata for the cycle following the load edge.
// ---------------------------------------------------------------------------
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_DW  = 24,
    parameter int SLOT_DW    = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            sclk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    i2s_tdm_tx_if.slave                     s_bus,
    output logic                            lrclk,
    output logic                            sdata,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int FRAME_DW = CHANNELS * SAMPLE_DW;
    localparam int BW       = $clog2(SLOT_DW);
    localparam int CW       = $clog2(CHANNELS);

    i2s_state_e          state_q;
    i2s_mode_e           mode_q,  mode_d;
    logic [BW-1:0]       bit_q,   bit_d;
    logic [CW-1:0]       slot_q,  slot_d;
    logic [FRAME_DW-1:0] frame_q, frame_d;
    logic                sdata_q, sdata_d;
    logic                lrclk_q, lrclk_d;
    logic                underrun_q, underrun_d;

    logic                last_bit, frame_end, load, run_d;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FRAME_DW-1:0] fifo_head;

    logic [SLOT_DW-1:0]  slot_word [CHANNELS];
    logic [SLOT_DW-1:0]  shifted_word;
    logic [CW-1:0]       slot_lead;
    logic                lj_now, lj_lead, tdm_sync, last_bit_d;

    // ---------------- frame buffer ----------------
    assign fifo_push     = s_bus.s_valid && !fifo_full;
    assign s_bus.s_ready = !fifo_full;

    i2s_frame_fifo #(
        .WIDTH (FRAME_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sclk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_push),
        .wr_data_i (s_bus.s_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // ---------------- position / frame next state ----------------
    always_comb begin
        last_bit   = (bit_q == BW'(SLOT_DW - 1));
        frame_end  = last_bit && (slot_q == CW'(CHANNELS - 1));
        load       = enable && ((state_q == ST_IDLE) || frame_end);
        run_d      = load || ((state_q == ST_RUN) && !frame_end);
        // An empty load never bypasses a same-cycle push: it sends silence.
        fifo_pop   = load && !fifo_empty;
        underrun_d = load && fifo_empty;

        frame_d = frame_q;
        mode_d  = mode_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        if (load) begin
            frame_d = fifo_empty ? '0 : fifo_head;
            mode_d  = mode_decode(mode);
            bit_d   = '0;
            slot_d  = '0;
        end else if (state_q == ST_RUN) begin
            if (frame_end) begin
                bit_d  = '0;
                slot_d = '0;
            end else if (last_bit) begin
                bit_d  = '0;
                slot_d = slot_q + CW'(1);
            end else begin
                bit_d  = bit_q + BW'(1);
            end
        end
    end

    // Each slot word holds its sample left-aligned with zero padding below.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_slot
        assign slot_word[gi] = SLOT_DW'(frame_d[gi*SAMPLE_DW +: SAMPLE_DW]) << (SLOT_DW - SAMPLE_DW);
    end

    // ---------------- output bit / word select for the next position ----------------
    always_comb begin
        shifted_word = slot_word[slot_d] << bit_d;
        last_bit_d   = (bit_d == BW'(SLOT_DW - 1));
        slot_lead    = slot_d;
        if (last_bit_d) begin
            slot_lead = (slot_d == CW'(CHANNELS - 1)) ? '0 : slot_d + CW'(1);
        end
        lj_now   = (slot_d    >= CW'(CHANNELS / 2));
        lj_lead  = (slot_lead >= CW'(CHANNELS / 2));   // I2S leads data by one bit
        tdm_sync = last_bit_d && (slot_d == CW'(CHANNELS - 1));

        sdata_d = run_d && shifted_word[SLOT_DW-1];
        case (mode_d)
            MODE_LJ:  lrclk_d = run_d && lj_now;
            MODE_TDM: lrclk_d = run_d && tdm_sync;
            default:  lrclk_d = run_d && lj_lead;
        endcase
    end

    // ---------------- sequencer with registered outputs ----------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_I2S;
            bit_q      <= '0;
            slot_q     <= '0;
            frame_q    <= '0;
            sdata_q    <= 1'b0;
            lrclk_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (load)                 state_q <= ST_RUN;
                ST_RUN:  if (frame_end && !enable) state_q <= ST_IDLE;
            endcase
            mode_q     <= mode_d;
            bit_q      <= bit_d;
            slot_q     <= slot_d;
            frame_q    <= frame_d;
            sdata_q    <= sdata_d;
            lrclk_q    <= lrclk_d;
            underrun_q <= underrun_d;
        end
    end

    assign sdata    = sdata_q;
    assign lrclk    = lrclk_q;
    assign underrun = underrun_q;
endmodule

// File: doc/i2s_tdm_tx.md
I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

Interface
REQ-001 The parameter SAMPLE_DW SHALL default to 24 and SHALL set the sample width per channel in bits (8..SLOT_DW).
REQ-002 The parameter SLOT_DW SHALL default to 32 and SHALL set the number of bit clocks per channel slot (16..32).
REQ-003 The parameter CHANNELS SHALL default to 2 and SHALL set the slots per frame (even, 2..8).
REQ-004 The parameter FIFO_DEPTH SHALL default to 4 and SHALL set the frame buffer depth (power of two, >=2).
REQ-005 The port sclk SHALL be an input of width 1 carrying the bit clock; all logic SHALL use its rising edge.
REQ-006 The port rst_n SHALL be an input of width 1 carrying the asynchronous, active-low reset.
REQ-007 The port enable SHALL be an input of width 1 that starts and stops frame transmission.
REQ-008 The port mode SHALL be an input of width 2: 0=I2S, 1=left-justified, 2=TDM/DSP, 3=reserved (treated as 0).
REQ-009 The port s_data SHALL be an input of width CHANNELS*SAMPLE_DW carrying one frame; channel 0 occupies the LSBs.
REQ-010 The ports s_valid (input, width 1) and s_ready (output, width 1) SHALL carry the frame push handshake.
REQ-011 The port lrclk SHALL be an output of width 1 carrying the word select (I2S, LJ) or the frame sync (TDM).
REQ-012 The port sdata SHALL be an output of width 1 carrying serial data, MSB first.
REQ-013 The port underrun SHALL be an output of width 1 pulsing for one cycle when a frame load finds the FIFO empty.
REQ-014 The port fifo_level SHALL be an output of width $clog2(FIFO_DEPTH+1) giving the number of frames buffered.

Function
REQ-015 A push SHALL occur on a cycle with s_valid&&s_ready, and s_ready SHALL equal !full.
REQ-016 The state machine SHALL have two states: IDLE (bit position p=0, sdata=0, lrclk=0) and RUN.
REQ-017 In IDLE with enable=1, the next edge SHALL load a frame, latch mode, set p=0 and enter RUN.
REQ-018 In RUN, p SHALL increment each cycle through 0..CHANNELS*SLOT_DW-1.
REQ-019 At p=CHANNELS*SLOT_DW-1 with enable=1, the block SHALL load the next frame and wrap p to 0; with enable=0 it SHALL return to IDLE, so deassertion mid-frame completes the current frame.
REQ-020 A frame load SHALL pop the FIFO head; if the FIFO is empty it SHALL load all-zero samples and pulse underrun.
REQ-021 A push and an empty-FIFO load in the same cycle SHALL accept the push and still underrun (no bypass).
REQ-022 Each slot SHALL carry its sample left-aligned MSB-first in the first SAMPLE_DW bit times, followed by zeros.
REQ-023 Mode SHALL be latched only at a frame load; changes mid-frame SHALL have no effect until the next frame.
REQ-024 LJ mode: lrclk SHALL be 0 for p < CHANNELS*SLOT_DW/2 and 1 otherwise, aligned with the data bits.
REQ-025 I2S mode: lrclk SHALL lead data by one sclk, i.e. the value LJ would output for (p+1) mod frame length, including the final frame cycle.
REQ-026 TDM mode: lrclk SHALL be 1 only at p=CHANNELS*SLOT_DW-1 (a one-cycle sync preceding slot 0), and 0 otherwise.
REQ-027 sdata and lrclk SHALL be registered outputs, with the first frame bit appearing one cycle after the load edge.

Reset
REQ-028 Reset SHALL force IDLE, empty the FIFO, and set lrclk=0, sdata=0, underrun=0, fifo_level=0 and s_ready=1.
REQ-029 Reset asserted mid-frame SHALL discard the frame in flight and all buffered frames immediately.

Structure
REQ-030 The mode encodings and the state encoding SHALL live in the shared package i2s_pkg.
REQ-031 Frame buffering SHALL be a sub-module named i2s_frame_fifo (synchronous FIFO, width CHANNELS*SAMPLE_DW, depth FIFO_DEPTH, level output).

Verification
REQ-032 Default parameters, LJ mode, push L=0xABCDEF and R=0x123456 -> sdata sequence is 0xABCDEF00 then 0x12345600, and lrclk toggles at p=32.
REQ-033 Same frame in I2S mode -> lrclk transitions one cycle before the first left and first right data bits.
REQ-034 CHANNELS=4, SLOT_DW=16, SAMPLE_DW=16, TDM mode -> exactly one lrclk pulse per 64 cycles, at p=63, with slots 0..3 serialized in order.
REQ-035 Enable with an empty FIFO -> zero frame transmitted and underrun high for exactly one cycle per frame load; pushing 5 frames at depth 4 -> s_ready low after the 4th push.
REQ-036 Drop enable at p=10 -> the frame completes, the block enters IDLE after p=63, and sdata=0; asserting rst_n=0 mid-frame -> outputs return to reset values at once.
